// File: rtl/dualmem_widen_pipe_if.sv
// dualmem_widen_pipe_if: narrow port A, wide port B and collision flag of the asymmetric dual-port RAM
interface dualmem_widen_pipe_if #(
  parameter int NARROW_W   = 16,
  parameter int RATIO      = 4,
  parameter int WIDE_DEPTH = 2048
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int AWB    = $clog2(WIDE_DEPTH);
  localparam int AWA    = AWB + $clog2(RATIO);
  logic                  a_req_i;
  logic                  a_we_i;
  logic [NARROW_W/8-1:0] a_be_i;
  logic [AWA-1:0]        a_addr_i;
  logic [NARROW_W-1:0]   a_wdata_i;
  logic [NARROW_W-1:0]   a_rdata_o;
  logic                  a_rvalid_o;
  logic                  b_req_i;
  logic                  b_we_i;
  logic [WIDE_W/8-1:0]   b_be_i;
  logic [AWB-1:0]        b_addr_i;
  logic [WIDE_W-1:0]     b_wdata_i;
  logic [WIDE_W-1:0]     b_rdata_o;
  logic                  b_rvalid_o;
  logic                  collision_o;
  logic                  coll_clr_i;
  modport slave (
    input  a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
    input  b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i, coll_clr_i,
    output a_rdata_o, a_rvalid_o, b_rdata_o, b_rvalid_o, collision_o
  );
  modport master (
    output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
    output b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i, coll_clr_i,
    input  a_rdata_o, a_rvalid_o, b_rdata_o, b_rvalid_o, collision_o
  );
endinterface

// File: rtl/dualmem_widen_pipe.sv
// dualmem_widen_pipe: asymmetric true-dual-port RAM, narrow port A / wide port B, read-first, B wins byte collisions
module dualmem_widen_pipe #(
  parameter int NARROW_W   = 16,
  parameter int RATIO      = 4,
  parameter int WIDE_DEPTH = 2048,
  parameter int OUT_REG    = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  dualmem_widen_pipe_if.slave  bus
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int NB_A   = NARROW_W / 8;
  localparam int NB_B   = WIDE_W / 8;
  localparam int LW     = $clog2(RATIO);
  localparam int AWB    = $clog2(WIDE_DEPTH);
  localparam int AWA    = AWB + LW;
  logic [WIDE_W-1:0]   mem [WIDE_DEPTH];
  logic [AWB-1:0]      a_word;
  logic [LW-1:0]       a_lane;
  logic                a_wr, a_rd, b_wr, b_rd, coll;
  logic [NB_B-1:0]     a_bew;
  logic [WIDE_W-1:0]   a_wwide, a_rword, b_rword;
  logic [NARROW_W-1:0] a_rlane;
  logic                a_v1_q, a_v1_d, a_v2_q, a_v2_d;
  logic                b_v1_q, b_v1_d, b_v2_q, b_v2_d;
  logic [NARROW_W-1:0] a_d1_q, a_d1_d, a_d2_q, a_d2_d;
  logic [WIDE_W-1:0]   b_d1_q, b_d1_d, b_d2_q, b_d2_d;
  logic                coll_q, coll_d;
  assign a_word = bus.a_addr_i[AWA-1:LW];
  assign a_lane = bus.a_addr_i[LW-1:0];
  always_comb begin
    a_wr    = bus.a_req_i & bus.a_we_i;
    a_rd    = bus.a_req_i & ~bus.a_we_i;
    b_wr    = bus.b_req_i & bus.b_we_i;
    b_rd    = bus.b_req_i & ~bus.b_we_i;
    a_bew   = NB_B'(bus.a_be_i) << (a_lane * NB_A);
    a_wwide = {RATIO{bus.a_wdata_i}};
    a_rword = mem[a_word];
    a_rlane = a_rword[a_lane*NARROW_W +: NARROW_W];
    b_rword = mem[bus.b_addr_i];
    coll    = a_wr & b_wr & (a_word == bus.b_addr_i) & |(a_bew & bus.b_be_i);
    coll_d  = coll | (coll_q & ~bus.coll_clr_i);
    a_v1_d  = a_rd;
    a_d1_d  = a_rd ? a_rlane : a_d1_q;
    a_v2_d  = a_v1_q;
    a_d2_d  = a_v1_q ? a_d1_q : a_d2_q;
    b_v1_d  = b_rd;
    b_d1_d  = b_rd ? b_rword : b_d1_q;
    b_v2_d  = b_v1_q;
    b_d2_d  = b_v1_q ? b_d1_q : b_d2_q;
  end
  // B is written last so its bytes override A's on a same-byte collision
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NB_B; j++) begin
      if (a_wr && a_bew[j]) mem[a_word][j*8 +: 8] <= a_wwide[j*8 +: 8];
      if (b_wr && bus.b_be_i[j]) mem[bus.b_addr_i][j*8 +: 8] <= bus.b_wdata_i[j*8 +: 8];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_v1_q <= 1'b0;
      a_v2_q <= 1'b0;
      b_v1_q <= 1'b0;
      b_v2_q <= 1'b0;
      a_d1_q <= '0;
      a_d2_q <= '0;
      b_d1_q <= '0;
      b_d2_q <= '0;
      coll_q <= 1'b0;
    end else begin
      a_v1_q <= a_v1_d;
      a_v2_q <= a_v2_d;
      b_v1_q <= b_v1_d;
      b_v2_q <= b_v2_d;
      a_d1_q <= a_d1_d;
      a_d2_q <= a_d2_d;
      b_d1_q <= b_d1_d;
      b_d2_q <= b_d2_d;
      coll_q <= coll_d;
    end
  end
  assign bus.a_rvalid_o  = OUT_REG != 0 ? a_v2_q : a_v1_q;
  assign bus.a_rdata_o   = OUT_REG != 0 ? a_d2_q : a_d1_q;
  assign bus.b_rvalid_o  = OUT_REG != 0 ? b_v2_q : b_v1_q;
  assign bus.b_rdata_o   = OUT_REG != 0 ? b_d2_q : b_d1_q;
  assign bus.collision_o = coll_q;
endmodule

// File: tb/tb_dualmem_widen_pipe.sv
// tb_dualmem_widen_pipe: directed checks of mapping, byte enables, read-first, collisions, pipelining and reset
module tb_dualmem_widen_pipe;
  localparam int OUT_REG = 1;
  localparam int LAT     = 1 + OUT_REG;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] model [16];
  dualmem_widen_pipe_if #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(2048)) bus ();
  dualmem_widen_pipe #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(2048), .OUT_REG(OUT_REG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    bus.a_req_i = 1'b0;
    bus.b_req_i = 1'b0;
    bus.coll_clr_i = 1'b0;
  endtask
  task automatic a_set(input logic we, input logic [12:0] addr, input logic [15:0] d, input logic [1:0] be);
    bus.a_req_i = 1'b1; bus.a_we_i = we; bus.a_addr_i = addr; bus.a_wdata_i = d; bus.a_be_i = be;
  endtask
  task automatic b_set(input logic we, input logic [10:0] addr, input logic [63:0] d, input logic [7:0] be);
    bus.b_req_i = 1'b1; bus.b_we_i = we; bus.b_addr_i = addr; bus.b_wdata_i = d; bus.b_be_i = be;
  endtask
  task automatic wait_a(input string tag, input logic [15:0] exp);
    int c = 0;
    do begin step(); c++; end while (!bus.a_rvalid_o && c < 6);
    chk({tag, "_lat"}, c, LAT);
    chk(tag, bus.a_rdata_o, exp);
  endtask
  task automatic wait_b(input string tag, input logic [63:0] exp);
    int c = 0;
    do begin step(); c++; end while (!bus.b_rvalid_o && c < 6);
    chk({tag, "_lat"}, c, LAT);
    chk(tag, bus.b_rdata_o, exp);
  endtask
  task automatic a_wr(input logic [12:0] addr, input logic [15:0] d, input logic [1:0] be);
    a_set(1'b1, addr, d, be);
    step();
  endtask
  task automatic a_rd(input string tag, input logic [12:0] addr, input logic [15:0] exp);
    a_set(1'b0, addr, 16'h0, 2'b00);
    wait_a(tag, exp);
  endtask
  task automatic b_rd(input string tag, input logic [10:0] addr, input logic [63:0] exp);
    b_set(1'b0, addr, 64'h0, 8'h00);
    wait_b(tag, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int p;
    bus.a_req_i = 0; bus.a_we_i = 0; bus.a_be_i = 0; bus.a_addr_i = 0; bus.a_wdata_i = 0;
    bus.b_req_i = 0; bus.b_we_i = 0; bus.b_be_i = 0; bus.b_addr_i = 0; bus.b_wdata_i = 0;
    bus.coll_clr_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_rdata", bus.a_rdata_o, 0);
    chk("rst_b_rdata", bus.b_rdata_o, 0);
    chk("rst_a_rvalid", bus.a_rvalid_o, 0);
    chk("rst_b_rvalid", bus.b_rvalid_o, 0);
    chk("rst_coll", bus.collision_o, 0);
    rst_n = 1'b1;
    step();
    // 1: narrow writes assemble one wide word, lane 0 in the LSBs
    for (int i = 0; i < 4; i++) begin
      a_wr(13'(i), 16'h1111 * 16'(i + 1), 2'b11);
      chk("wr_no_rvalid", {bus.a_rvalid_o, bus.b_rvalid_o}, 0);
    end
    b_rd("t1_b_w0", 11'd0, 64'h4444_3333_2222_1111);
    // 2: partial wide write, then partial and empty narrow writes
    a_wr(13'd22, 16'h7777, 2'b11);
    a_wr(13'd23, 16'h8888, 2'b11);
    b_set(1'b1, 11'd5, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
    step();
    a_rd("t2_n20", 13'd20, 16'hF00D);
    a_rd("t2_n21", 13'd21, 16'hCAFE);
    a_rd("t2_n22", 13'd22, 16'h7777);
    a_rd("t2_n23", 13'd23, 16'h8888);
    a_wr(13'd21, 16'h1234, 2'b01);
    a_wr(13'd20, 16'hFFFF, 2'b00);
    a_rd("t2_be01", 13'd21, 16'hCA34);
    a_rd("t2_be00", 13'd20, 16'hF00D);
    b_rd("t2_b_w5", 11'd5, 64'h8888_7777_CA34_F00D);
    // 3: same-byte collision, sticky flag, clear, disjoint bytes, set-wins
    a_set(1'b1, 13'd8, 16'hAAAA, 2'b11);
    b_set(1'b1, 11'd2, 64'h5555, 8'h03);
    step();
    chk("t3_coll_set", bus.collision_o, 1);
    step();
    chk("t3_coll_sticky", bus.collision_o, 1);
    bus.coll_clr_i = 1'b1;
    step();
    chk("t3_coll_clr", bus.collision_o, 0);
    a_rd("t3_b_wins", 13'd8, 16'h5555);
    a_set(1'b1, 13'd9, 16'hBBBB, 2'b11);
    b_set(1'b1, 11'd2, 64'h77, 8'h01);
    step();
    chk("t3_no_coll", bus.collision_o, 0);
    a_rd("t3_n8_merge", 13'd8, 16'h5577);
    a_rd("t3_n9_merge", 13'd9, 16'hBBBB);
    a_set(1'b1, 13'd10, 16'h00CC, 2'b01);
    b_set(1'b1, 11'd2, 64'h0000_00DD_0000_0000, 8'h10);
    bus.coll_clr_i = 1'b1;
    step();
    chk("t3_set_wins", bus.collision_o, 1);
    bus.coll_clr_i = 1'b1;
    step();
    chk("t3_clr2", bus.collision_o, 0);
    // 4: read-first against a same-cycle write from the other port
    a_wr(13'd4, 16'h4040, 2'b11);
    a_set(1'b0, 13'd4, 16'h0, 2'b00);
    b_set(1'b1, 11'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wait_a("t4_a_rf", 16'h4040);
    a_rd("t4_a_new", 13'd4, 16'hFFFF);
    step();
    step();
    chk("t4_hold_data", bus.a_rdata_o, 16'hFFFF);
    chk("t4_hold_rvalid", bus.a_rvalid_o, 0);
    b_set(1'b0, 11'd1, 64'h0, 8'h00);
    a_set(1'b1, 13'd4, 16'h1234, 2'b11);
    wait_b("t4_b_rf", 64'hFFFF_FFFF_FFFF_FFFF);
    a_rd("t4_n4", 13'd4, 16'h1234);
    b_rd("t4_w1", 11'd1, 64'hFFFF_FFFF_FFFF_1234);
    // 5: sixteen back-to-back reads against a model
    for (int i = 0; i < 16; i++) begin
      model[i] = 16'($urandom);
      a_wr(13'(32 + i), model[i], 2'b11);
    end
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          a_set(1'b0, 13'(32 + i), 16'h0, 2'b00);
          step();
        end
      end
      begin
        int k = 0, first = -1, last = -1;
        for (int cyc = 0; cyc < 30 && k < 16; cyc++) begin
          @(negedge clk);
          if (bus.a_rvalid_o) begin
            chk($sformatf("t5_b2b%0d", k), bus.a_rdata_o, model[k]);
            if (first < 0) first = cyc;
            last = cyc;
            k++;
          end
        end
        chk("t5_count", k, 16);
        chk("t5_span", last - first, 15);
      end
    join
    step();
    // 6: reset between accept and rvalid drops the reads but keeps RAM
    a_set(1'b0, 13'd4, 16'h0, 2'b00);
    b_set(1'b0, 11'd5, 64'h0, 8'h00);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_a_rdata", bus.a_rdata_o, 0);
    chk("t6_b_rdata", bus.b_rdata_o, 0);
    chk("t6_rvalid", {bus.a_rvalid_o, bus.b_rvalid_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    repeat (4) begin
      step();
      p += int'(bus.a_rvalid_o) + int'(bus.b_rvalid_o);
    end
    chk("t6_no_rvalid", p, 0);
    a_rd("t6_keep_n4", 13'd4, 16'h1234);
    b_rd("t6_keep_w5", 11'd5, 64'h8888_7777_CA34_F00D);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
